// File: rtl/sram_ctrl_be_pkg.sv
// Shared types for the byte-enable SRAM controller: fill FSM states and the
// per-stage response record carried down the read pipe.
package sram_ctrl_pkg;

   typedef enum logic {
      INIT = 1'b0,
      IDLE = 1'b1
   } state_e;

   // rd marks an in-range read whose data is taken from the array read register
   typedef struct packed {
      logic valid;
      logic err;
      logic rd;
   } resp_t;

   localparam int unsigned MAX_RD_LATENCY = 4;

endpackage

// File: rtl/sram_ctrl_be_if.sv
// Request/response bundle between a bus agent (master) and the SRAM controller (slave).
interface sram_ctrl_be_if #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 9
) ();

   logic                    clear_i;
   logic                    valid_i;
   logic                    ready_o;
   logic                    wr_rd_i;
   logic [ADDR_WIDTH-1:0]   addr_i;
   logic [WIDTH-1:0]        wdata_i;
   logic [WIDTH/8-1:0]      be_i;
   logic                    rvalid_o;
   logic [WIDTH-1:0]        rdata_o;
   logic                    err_o;
   logic                    init_done_o;

   modport master (
      output clear_i, valid_i, wr_rd_i, addr_i, wdata_i, be_i,
      input  ready_o, rvalid_o, rdata_o, err_o, init_done_o
   );

   modport slave (
      input  clear_i, valid_i, wr_rd_i, addr_i, wdata_i, be_i,
      output ready_o, rvalid_o, rdata_o, err_o, init_done_o
   );

endinterface

// File: rtl/sram_ctrl_be_rd_pipe.sv
// Response shift register, RD_LATENCY stages deep. Stage 1 is loaded on accept and
// picks up its data from the array read register one cycle later.
module sram_rd_pipe
   import sram_ctrl_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             err_i,
   input  logic             rd_i,
   input  logic [WIDTH-1:0] rd_data_i,
   output logic             rvalid_o,
   output logic             err_o,
   output logic [WIDTH-1:0] rdata_o
);

   resp_t            stage      [RD_LATENCY];
   logic [WIDTH-1:0] stage_data [RD_LATENCY];

   for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
      resp_t resp_q;

      if (gi == 0) begin : g_head
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               resp_q <= '0;
            end else begin
               resp_q.valid <= load_i;
               resp_q.err   <= load_i & err_i;
               resp_q.rd    <= load_i & rd_i;
            end
         end
         // the array read register only holds meaningful data for in-range reads
         assign stage_data[gi] = resp_q.rd ? rd_data_i : '0;
      end else begin : g_tail
         logic [WIDTH-1:0] data_q;
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               resp_q <= '0;
               data_q <= '0;
            end else begin
               resp_q <= stage[gi-1];
               data_q <= stage_data[gi-1];
            end
         end
         assign stage_data[gi] = data_q;
      end

      assign stage[gi] = resp_q;
   end

   assign rvalid_o = stage[RD_LATENCY-1].valid;
   assign err_o    = stage[RD_LATENCY-1].err;
   assign rdata_o  = stage[RD_LATENCY-1].rd ? stage_data[RD_LATENCY-1] : '0;

endmodule

// File: rtl/sram_ctrl_be.sv
// Single-port SRAM with byte-masked writes, range-checked requests, a fixed-latency
// response pipe and a hardware zero-fill sequencer that runs after reset or clear.
module sram_ctrl_be
   import sram_ctrl_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 512,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int RD_LATENCY = 1
) (
   input logic          clk_i,
   input logic          rst_ni,
   sram_ctrl_be_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH);
   localparam int LANES = WIDTH / 8;
   localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_CMP = (ADDR_WIDTH + 1)'(DEPTH);

   state_e           state_q, state_next;
   logic [CNT_W-1:0] cnt_q, cnt_next;
   logic             accept;
   logic             in_range;
   logic             init_we;
   logic             req_we;
   logic             req_re;
   logic [CNT_W-1:0] ram_addr;
   logic [WIDTH-1:0] rd_data;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_next;
         cnt_q   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_q;
      cnt_next   = cnt_q;
      case (state_q)
         INIT: begin
            if (bus.clear_i) begin
               cnt_next = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_q + 1'b1;
            end
         end
         IDLE: begin
            if (bus.clear_i) begin
               state_next = INIT;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = INIT;
            cnt_next   = '0;
         end
      endcase
   end

   assign bus.ready_o     = (state_q == IDLE);
   assign bus.init_done_o = (state_q == IDLE);

   assign accept   = bus.valid_i && (state_q == IDLE);
   assign in_range = ({1'b0, bus.addr_i} < DEPTH_CMP);
   assign init_we  = (state_q == INIT);
   assign req_we   = accept &&  bus.wr_rd_i && in_range;
   assign req_re   = accept && !bus.wr_rd_i && in_range;
   // the fill sequencer owns the single port while filling; requests are held off then
   assign ram_addr = init_we ? cnt_q : bus.addr_i[CNT_W-1:0];

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte_q;

      always_ff @(posedge clk_i) begin
         if (init_we) begin
            mem[ram_addr] <= 8'h00;
         end else if (req_we && bus.be_i[gi]) begin
            mem[ram_addr] <= bus.wdata_i[8*gi +: 8];
         end
         if (req_re) begin
            rd_byte_q <= mem[ram_addr];
         end
      end

      assign rd_data[8*gi +: 8] = rd_byte_q;
   end

   sram_rd_pipe #(
      .WIDTH      (WIDTH),
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_pipe (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load_i    (accept),
      .err_i     (!in_range),
      .rd_i      (req_re),
      .rd_data_i (rd_data),
      .rvalid_o  (bus.rvalid_o),
      .err_o     (bus.err_o),
      .rdata_o   (bus.rdata_o)
   );

endmodule

// File: tb/tb_sram_ctrl_be.sv
// Scoreboard bench for sram_ctrl_be across three configurations (latency 1/3/2,
// depth 512/100/16); drivers push expected responses, negedge monitors pop and compare.
module tb_sram_ctrl_be;

   localparam int LAT_A = 1;
   localparam int LAT_B = 3;
   localparam int LAT_C = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic rst_c_n;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc++;

   sram_ctrl_be_if #(.WIDTH(32), .ADDR_WIDTH(9)) ifa ();
   sram_ctrl_be_if #(.WIDTH(32), .ADDR_WIDTH(7)) ifb ();
   sram_ctrl_be_if #(.WIDTH(32), .ADDR_WIDTH(4)) ifc ();

   sram_ctrl_be #(.WIDTH(32), .DEPTH(512), .ADDR_WIDTH(9), .RD_LATENCY(LAT_A))
      dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa));
   sram_ctrl_be #(.WIDTH(32), .DEPTH(100), .ADDR_WIDTH(7), .RD_LATENCY(LAT_B))
      dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb));
   sram_ctrl_be #(.WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4), .RD_LATENCY(LAT_C))
      dut_c (.clk_i(clk), .rst_ni(rst_c_n), .bus(ifc));

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int qsize(input int sel);
      case (sel)
         0:       return qa.size();
         1:       return qb.size();
         default: return qc.size();
      endcase
   endfunction

   function automatic exp_t qpop(input int sel);
      case (sel)
         0:       return qa.pop_front();
         1:       return qb.pop_front();
         default: return qc.pop_front();
      endcase
   endfunction

   function automatic int qdue(input int sel);
      case (sel)
         0:       return qa[0].due;
         1:       return qb[0].due;
         default: return qc[0].due;
      endcase
   endfunction

   task automatic mon_step(input int sel, input logic rv, input logic er, input logic [31:0] d);
      exp_t e;
      if (rv) begin
         if (qsize(sel) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rvalid dut%0d: got rvalid=1 required none (cycle %0d)", sel, cyc);
         end else begin
            e = qpop(sel);
            $display("resp dut%0d cycle=%0d err=%0b data=%h (exp err=%0b data=%h due=%0d)",
                     sel, cyc, er, d, e.err, e.data, e.due);
            chk($sformatf("err_dut%0d", sel), {31'd0, er}, {31'd0, e.err});
            chk($sformatf("rdata_dut%0d", sel), d, e.data);
            chk($sformatf("latency_dut%0d", sel), 32'(cyc), 32'(e.due));
         end
      end else if (qsize(sel) != 0 && qdue(sel) <= cyc) begin
         e = qpop(sel);
         total++;
         bad++;
         $display("FAIL missing_resp dut%0d: got no rvalid required response due cycle %0d", sel, e.due);
      end
   endtask

   always @(negedge clk) mon_step(0, ifa.rvalid_o, ifa.err_o, ifa.rdata_o);
   always @(negedge clk) mon_step(1, ifb.rvalid_o, ifb.err_o, ifb.rdata_o);
   always @(negedge clk) mon_step(2, ifc.rvalid_o, ifc.err_o, ifc.rdata_o);

   function automatic logic rdy(input int sel);
      case (sel)
         0:       return ifa.ready_o;
         1:       return ifb.ready_o;
         default: return ifc.ready_o;
      endcase
   endfunction

   task automatic req(input int sel, input logic wr, input int addr, input logic [31:0] data,
                      input logic [3:0] be, input logic clr, input logic exp_err,
                      input logic [31:0] exp_data);
      exp_t e;
      @(negedge clk);
      e.err  = exp_err;
      e.data = exp_data;
      case (sel)
         0: begin
            ifa.valid_i = 1'b1; ifa.wr_rd_i = wr; ifa.addr_i = addr[8:0];
            ifa.wdata_i = data; ifa.be_i = be; ifa.clear_i = clr;
            e.due = cyc + LAT_A; qa.push_back(e);
         end
         1: begin
            ifb.valid_i = 1'b1; ifb.wr_rd_i = wr; ifb.addr_i = addr[6:0];
            ifb.wdata_i = data; ifb.be_i = be; ifb.clear_i = clr;
            e.due = cyc + LAT_B; qb.push_back(e);
         end
         default: begin
            ifc.valid_i = 1'b1; ifc.wr_rd_i = wr; ifc.addr_i = addr[3:0];
            ifc.wdata_i = data; ifc.be_i = be; ifc.clear_i = clr;
            e.due = cyc + LAT_C; qc.push_back(e);
         end
      endcase
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      ifa.valid_i = 1'b0; ifa.clear_i = 1'b0;
      ifb.valid_i = 1'b0; ifb.clear_i = 1'b0;
      ifc.valid_i = 1'b0; ifc.clear_i = 1'b0;
   endtask

   // counts rising edges until ready_o is seen high, bounded
   task automatic count_ready(input int sel, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!rdy(sel) && n < 5000);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      ifa.valid_i = 0; ifa.clear_i = 0; ifa.wr_rd_i = 0; ifa.addr_i = '0; ifa.wdata_i = '0; ifa.be_i = '0;
      ifb.valid_i = 0; ifb.clear_i = 0; ifb.wr_rd_i = 0; ifb.addr_i = '0; ifb.wdata_i = '0; ifb.be_i = '0;
      ifc.valid_i = 0; ifc.clear_i = 0; ifc.wr_rd_i = 0; ifc.addr_i = '0; ifc.wdata_i = '0; ifc.be_i = '0;
      rst_n   = 1'b0;
      rst_c_n = 1'b0;

      repeat (3) @(negedge clk);
      chk("reset_outputs_a", {27'd0, ifa.ready_o, ifa.rvalid_o, ifa.err_o, ifa.init_done_o, |ifa.rdata_o}, 32'd0);
      chk("reset_outputs_b", {27'd0, ifb.ready_o, ifb.rvalid_o, ifb.err_o, ifb.init_done_o, |ifb.rdata_o}, 32'd0);
      chk("reset_outputs_c", {27'd0, ifc.ready_o, ifc.rvalid_o, ifc.err_o, ifc.init_done_o, |ifc.rdata_o}, 32'd0);

      // zero-fill after reset, then every word reads back as 0
      @(negedge clk);
      rst_n   = 1'b1;
      rst_c_n = 1'b1;
      count_ready(0, n);
      chk("init_cycles_a", 32'(n), 32'd512);
      chk("init_done_a", {31'd0, ifa.init_done_o}, 32'd1);
      for (int i = 0; i < 512; i++) req(0, 1'b0, i, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      idle();

      // byte-masked overwrite, read immediately after the second write
      req(0, 1'b1, 'h10, 32'hA5A5_A5A5, 4'hF, 1'b0, 1'b0, 32'h0);
      req(0, 1'b1, 'h10, 32'h1234_5678, 4'b0101, 1'b0, 1'b0, 32'h0);
      req(0, 1'b0, 'h10, 32'h0, 4'h0, 1'b0, 1'b0, 32'hA534_A578);
      idle();

      // latency 3: preload then four back-to-back reads
      req(1, 1'b1, 1, 32'h11, 4'hF, 1'b0, 1'b0, 32'h0);
      req(1, 1'b1, 2, 32'h22, 4'hF, 1'b0, 1'b0, 32'h0);
      req(1, 1'b1, 3, 32'h33, 4'hF, 1'b0, 1'b0, 32'h0);
      req(1, 1'b1, 4, 32'h44, 4'hF, 1'b0, 1'b0, 32'h0);
      req(1, 1'b0, 1, 32'h0, 4'h0, 1'b0, 1'b0, 32'h11);
      req(1, 1'b0, 2, 32'h0, 4'h0, 1'b0, 1'b0, 32'h22);
      req(1, 1'b0, 3, 32'h0, 4'h0, 1'b0, 1'b0, 32'h33);
      req(1, 1'b0, 4, 32'h0, 4'h0, 1'b0, 1'b0, 32'h44);

      // out-of-range accesses on a non-power-of-2 depth
      req(1, 1'b1, 99,  32'h0000_0099, 4'hF, 1'b0, 1'b0, 32'h0);
      req(1, 1'b1, 100, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h0);
      req(1, 1'b0, 100, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0);
      req(1, 1'b0, 127, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0);
      req(1, 1'b0, 99,  32'h0, 4'h0, 1'b0, 1'b0, 32'h0000_0099);
      idle();

      // clear from IDLE, with a write accepted in the same cycle as clear_i
      req(0, 1'b1, 5, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0);
      req(0, 1'b0, 5, 32'h0, 4'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
      req(0, 1'b1, 7, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 32'h0);
      idle();
      count_ready(0, n);
      chk("clear_idle_cycles", 32'(n), 32'd512);
      req(0, 1'b0, 5, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      req(0, 1'b0, 7, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);

      // clear pulsed again part-way through the fill restarts the full count
      req(0, 1'b1, 5, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0);
      idle();
      ifa.clear_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifa.clear_i = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk);
      chk("mid_init_ready_low", {31'd0, ifa.ready_o}, 32'd0);
      ifa.clear_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifa.clear_i = 1'b0;
      count_ready(0, n);
      chk("clear_mid_init_cycles", 32'(n) + 32'd0, 32'd511 + 32'd1);
      req(0, 1'b0, 5, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      idle();

      // reset while a latency-2 read is in flight discards its response
      @(negedge clk);
      ifc.valid_i = 1'b1; ifc.wr_rd_i = 1'b0; ifc.addr_i = 4'd3;
      @(posedge clk);
      @(negedge clk);
      ifc.valid_i = 1'b0;
      rst_c_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("reset_flush_c", {27'd0, ifc.ready_o, ifc.rvalid_o, ifc.err_o, ifc.init_done_o, |ifc.rdata_o}, 32'd0);
      end
      rst_c_n = 1'b1;
      count_ready(2, n);
      chk("init_cycles_c", 32'(n), 32'd16);
      req(2, 1'b0, 3, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      idle();

      repeat (10) @(negedge clk);
      chk("drain_a", 32'(qa.size()), 32'd0);
      chk("drain_b", 32'(qb.size()), 32'd0);
      chk("drain_c", 32'(qc.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
